// File: rtl/burst_ram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : burst_ram_pkg                                              |
// | Brief    : Shared types and constants for the burst RAM model         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package burst_ram_pkg;

   localparam int BURST_BEATS    = 4;
   localparam int BYTES_PER_WORD = 8;

   // One-hot controller states
   typedef enum logic [4:0] {
      INIT       = 5'b00001,
      IDLE       = 5'b00010,
      WRITE      = 5'b00100,
      READ_WAIT  = 5'b01000,
      READ_BURST = 5'b10000
   } state_t;

endpackage : burst_ram_pkg
`default_nettype wire

// File: rtl/burst_ram_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : burst_ram_array                                            |
// | Brief    : Simple dual-port 64-bit byte-enabled RAM, registered read  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module burst_ram_array
   import burst_ram_pkg::*;
#(
   parameter string DATA_FILE  = "",
   parameter int    ADDR_WIDTH = 12
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [ADDR_WIDTH-1:0]     wr_addr,
   input  logic [63:0]               wr_data,
   input  logic [BYTES_PER_WORD-1:0] wr_be,
   input  logic                      rd_en,
   input  logic [ADDR_WIDTH-1:0]     rd_addr,
   output logic [63:0]               rd_data
);

   localparam int c_WORDS = 1 << ADDR_WIDTH;

   logic [63:0] r_mem [c_WORDS];

   // Power-up image: all zeros
   initial begin
      for (int i = 0; i < c_WORDS; i++) begin
         r_mem[i] = '0;
      end
   end

   // Byte-enabled write port; storage itself is never reset
   always @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (wr_be[b]) begin
               r_mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
   end

   // Registered read port; output register clears on reset so it is never X
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= r_mem[rd_addr];
      end
   end

endmodule : burst_ram_array
`default_nettype wire

// File: rtl/burst_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : burst_ram                                                  |
// | Brief    : Behavioural PSRAM stand-in with fixed 4-beat bursts,       |
// |            start-up calibration delay and sticky drop flag            |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module burst_ram
   import burst_ram_pkg::*;
#(
   parameter string DATA_FILE                = "",
   parameter int    DEPTH_BITWIDTH           = 21,
   parameter int    RAM_WORDS_BITWIDTH       = 12,
   parameter int    CYCLES_BEFORE_DATA_VALID = 6,
   parameter int    CYCLES_BEFORE_INITIATED  = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd,
   input  logic                      cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0] addr,
   input  logic [63:0]               wr_data,
   input  logic [7:0]                data_mask,
   output logic [63:0]               rd_data,
   output logic                      rd_data_valid,
   output logic                      init_calib,
   output logic                      busy,
   output logic                      cmd_dropped
);

   localparam int c_INIT_W = $clog2(CYCLES_BEFORE_INITIATED + 1);
   localparam int c_BEAT_W = $clog2(BURST_BEATS + 1);
   localparam logic [c_INIT_W-1:0] c_INIT_LAST = c_INIT_W'(CYCLES_BEFORE_INITIATED - 1);
   localparam logic [c_BEAT_W-1:0] c_BEATS     = c_BEAT_W'(BURST_BEATS);
   localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_BEATS - 1);
   // Read data leaves the array one cycle after issue, and the first issue
   // happens one cycle after entering READ_BURST, hence the offset of 3.
   localparam logic [4:0] c_WAIT_LOAD =
      5'((CYCLES_BEFORE_DATA_VALID >= 3) ? CYCLES_BEFORE_DATA_VALID - 3 : 0);

   state_t                        r_state, w_state_nxt;
   logic [c_INIT_W-1:0]           r_init_cnt;
   logic [4:0]                    r_wait_cnt;
   logic [c_BEAT_W-1:0]           r_beat;
   logic [RAM_WORDS_BITWIDTH-1:0] r_base;
   logic                          r_rd_valid;
   logic                          r_cmd_dropped;

   logic                          w_accept;
   logic                          w_wr_en;
   logic                          w_rd_en;
   logic [RAM_WORDS_BITWIDTH-1:0] w_idx;
   logic [RAM_WORDS_BITWIDTH-1:0] w_beat_idx;
   logic [RAM_WORDS_BITWIDTH-1:0] w_wr_addr;
   logic                          w_unused_addr;

   assign w_idx         = addr[3 +: RAM_WORDS_BITWIDTH];
   assign w_beat_idx    = r_base + RAM_WORDS_BITWIDTH'(r_beat);
   assign w_accept      = (r_state == IDLE) && cmd_en;
   // Byte offset and aliased upper address bits are intentionally ignored
   assign w_unused_addr = ^addr;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode plus storage port control
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_wr_addr   = w_beat_idx;
      w_rd_en     = 1'b0;
      unique case (r_state)
         INIT: begin
            if (r_init_cnt == c_INIT_LAST) w_state_nxt = IDLE;
         end
         IDLE: begin
            if (cmd_en) begin
               w_wr_addr = w_idx;
               w_wr_en   = cmd;
               if (cmd)                                 w_state_nxt = WRITE;
               else if (CYCLES_BEFORE_DATA_VALID <= 2)  w_state_nxt = READ_BURST;
               else                                     w_state_nxt = READ_WAIT;
            end
         end
         WRITE: begin
            w_wr_en = 1'b1;
            if (r_beat == c_LAST_BEAT) w_state_nxt = IDLE;
         end
         READ_WAIT: begin
            if (r_wait_cnt == 5'd0) w_state_nxt = READ_BURST;
         end
         READ_BURST: begin
            // Extra cycle at beat count 4 covers the last beat leaving rd_data
            w_rd_en = (r_beat < c_BEATS);
            if (r_beat == c_BEATS) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = INIT;
         end
      endcase
      // A reset edge must never commit a write beat
      if (!rst_n) w_wr_en = 1'b0;
   end

   // Start-up, latency and beat counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_init_cnt <= '0;
         r_wait_cnt <= '0;
         r_beat     <= '0;
         r_base     <= '0;
      end else begin
         if (r_state == INIT && r_init_cnt != c_INIT_LAST) begin
            r_init_cnt <= r_init_cnt + c_INIT_W'(1);
         end
         if (w_accept) begin
            r_base     <= w_idx;
            r_beat     <= cmd ? c_BEAT_W'(1) : '0;
            r_wait_cnt <= c_WAIT_LOAD;
         end else if (r_state == WRITE || r_state == READ_BURST) begin
            r_beat <= r_beat + c_BEAT_W'(1);
         end else if (r_state == READ_WAIT) begin
            r_wait_cnt <= r_wait_cnt - 5'd1;
         end
      end
   end

   // Read-valid pipeline and sticky drop flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rd_valid    <= 1'b0;
         r_cmd_dropped <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_en;
         if (cmd_en && r_state != IDLE) r_cmd_dropped <= 1'b1;
      end
   end

   burst_ram_array #(
      .DATA_FILE  (DATA_FILE),
      .ADDR_WIDTH (RAM_WORDS_BITWIDTH)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_wr_en),
      .wr_addr (w_wr_addr),
      .wr_data (wr_data),
      .wr_be   (~data_mask),
      .rd_en   (w_rd_en),
      .rd_addr (w_beat_idx),
      .rd_data (rd_data)
   );

   assign rd_data_valid = r_rd_valid;
   assign init_calib    = (r_state != INIT);
   assign busy          = (r_state == WRITE) || (r_state == READ_WAIT) || (r_state == READ_BURST);
   assign cmd_dropped   = r_cmd_dropped;

endmodule : burst_ram
`default_nettype wire

// File: tb/tb_burst_ram.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_burst_ram                                               |
// | Brief    : Self-checking bench for burst_ram                          |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_burst_ram;

   localparam int AW = 21;
   localparam int RW = 4;
   localparam int L  = 6;
   localparam int CI = 10;
   localparam int NW = 1 << RW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd = 1'b0;
   logic          cmd_en = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [63:0]   wr_data = '0;
   logic [7:0]    data_mask = '0;
   logic [63:0]   rd_data;
   logic          rd_data_valid;
   logic          init_calib;
   logic          busy;
   logic          cmd_dropped;

   int            total = 0;
   int            bad = 0;
   logic [63:0]   model [NW];
   logic          exp_dropped = 1'b0;

   typedef struct {
      logic [AW-1:0]     waddr;
      logic [3:0][63:0]  wd;
      logic [3:0][7:0]   wm;
      logic [AW-1:0]     raddr;
      logic [3:0][63:0]  exp;
   } vec_t;

   vec_t vecs [5];

   burst_ram #(
      .DATA_FILE                (""),
      .DEPTH_BITWIDTH           (AW),
      .RAM_WORDS_BITWIDTH       (RW),
      .CYCLES_BEFORE_DATA_VALID (L),
      .CYCLES_BEFORE_INITIATED  (CI)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd           (cmd),
      .cmd_en        (cmd_en),
      .addr          (addr),
      .wr_data       (wr_data),
      .data_mask     (data_mask),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .init_calib    (init_calib),
      .busy          (busy),
      .cmd_dropped   (cmd_dropped)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk1(input string n, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", n, act, exp, $time);
      end
   endtask

   task automatic chk64(input string n, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // Word hit by beat k of a burst starting at byte address a
   function automatic int widx(input logic [AW-1:0] a, input int k);
      return (int'(a >> 3) + k) % NW;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                         input logic [7:0] m);
      logic [63:0] r;
      r = old;
      for (int b = 0; b < 8; b++) if (!m[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic vec_t mk(input logic [AW-1:0] wa,
                               input logic [63:0] d0, input logic [63:0] d1,
                               input logic [63:0] d2, input logic [63:0] d3,
                               input logic [7:0] m0, input logic [7:0] m1,
                               input logic [7:0] m2, input logic [7:0] m3,
                               input logic [AW-1:0] ra,
                               input logic [63:0] e0, input logic [63:0] e1,
                               input logic [63:0] e2, input logic [63:0] e3);
      vec_t v;
      v.waddr = wa; v.raddr = ra;
      v.wd = {d3, d2, d1, d0};
      v.wm = {m3, m2, m1, m0};
      v.exp = {e3, e2, e1, e0};
      return v;
   endfunction

   task automatic do_reset(input int drop_cycle);
      rst_n = 1'b0; cmd_en = 1'b0;
      tick(); tick();
      chk1("rst_valid", rd_data_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_init", init_calib, 1'b0);
      chk1("rst_dropped", cmd_dropped, 1'b0);
      chk64("rst_rd_data", rd_data, 64'h0);
      rst_n = 1'b1;
      exp_dropped = 1'b0;
      for (int k = 1; k <= CI; k++) begin
         cmd = 1'b0;
         cmd_en = (k == drop_cycle);
         if (k == drop_cycle) exp_dropped = 1'b1;
         tick();
         chk1("init_calib", init_calib, k == CI);
         chk1("init_busy", busy, 1'b0);
         chk1("init_dropped", cmd_dropped, exp_dropped);
      end
      cmd_en = 1'b0;
   endtask

   task automatic write_burst(input logic [AW-1:0] a, input logic [3:0][63:0] d,
                              input logic [3:0][7:0] m);
      for (int k = 0; k < 4; k++) begin
         cmd = 1'b1;
         cmd_en = (k == 0);
         addr = (k == 0) ? a : AW'($urandom);
         wr_data = d[k];
         data_mask = m[k];
         tick();
         chk1("wr_busy", busy, k < 3);
         chk1("wr_valid", rd_data_valid, 1'b0);
         model[widx(a, k)] = merge(model[widx(a, k)], d[k], m[k]);
      end
      cmd_en = 1'b0;
   endtask

   // drop_at > 0 injects a stray write command after that many cycles
   task automatic read_burst(input logic [AW-1:0] a, input logic [3:0][63:0] e,
                             input int drop_at);
      logic v;
      cmd = 1'b0; cmd_en = 1'b1; addr = a;
      for (int k = 1; k <= L + 4; k++) begin
         tick();
         cmd_en = 1'b0;
         addr = AW'($urandom);
         v = (k >= L) && (k <= L + 3);
         chk1("rd_valid", rd_data_valid, v);
         chk1("rd_busy", busy, k <= L + 3);
         chk1("rd_dropped", cmd_dropped, exp_dropped);
         if (v) chk64("rd_data", rd_data, e[k - L]);
         if (k == drop_at) begin
            cmd = 1'b1; cmd_en = 1'b1; wr_data = 64'hDEAD_BEEF_DEAD_BEEF; data_mask = 8'h00;
            exp_dropped = 1'b1;
         end
      end
      cmd_en = 1'b0;
   endtask

   task automatic read_model(input logic [AW-1:0] a, input int drop_at);
      logic [3:0][63:0] e;
      for (int k = 0; k < 4; k++) e[k] = model[widx(a, k)];
      read_burst(a, e, drop_at);
   endtask

   initial begin
      logic [AW-1:0]    ra;
      logic [3:0][63:0] rd;
      logic [3:0][7:0]  rm;

      for (int i = 0; i < NW; i++) model[i] = 64'h0;

      vecs[0] = mk(21'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 8'h00, 8'h00, 8'h00, 8'h00,
                   21'h40, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      vecs[1] = mk(21'h20, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 64'h6, 64'h7, 8'h0F, 8'hFF, 8'hFF, 8'hFF,
                   21'h20, 64'hFFFF_FFFF_0000_0000, 64'h0, 64'h0, 64'h0);
      vecs[2] = mk(21'h70, 64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
                   64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D, 8'h00, 8'h00, 8'h00, 8'h00,
                   21'h0, 64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D, 64'h0, 64'h0);
      vecs[3] = mk(21'h40, 64'h9, 64'h9, 64'h9, 64'h9, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                   21'h147, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
      vecs[4] = mk(21'h28, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                   64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hAA, 8'h55, 8'hF0, 8'h00,
                   21'h28, 64'h0023_0067_00AB_00EF, 64'h0100_4500_8900_CD00,
                   64'h0000_0000_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

      // Start-up: init timing with a command during INIT, then clean reset
      do_reset(5);
      chk1("init_cmd_not_taken", busy, 1'b0);
      do_reset(0);

      // Directed table
      for (int i = 0; i < 5; i++) begin
         write_burst(vecs[i].waddr, vecs[i].wd, vecs[i].wm);
         read_burst(vecs[i].raddr, vecs[i].exp, 0);
      end

      // Second command two cycles into a read is dropped
      read_model(21'h40, 2);
      tick();
      chk1("drop_idle_busy", busy, 1'b0);
      chk1("drop_idle_valid", rd_data_valid, 1'b0);
      read_model(21'h40, 0);

      // Randomized traffic against the word model
      for (int i = 0; i < 40; i++) begin
         ra = AW'($urandom);
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
            tick();
            chk1("gap_busy", busy, 1'b0);
            chk1("gap_valid", rd_data_valid, 1'b0);
         end
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < 4; k++) begin
               rd[k] = {$urandom, $urandom};
               rm[k] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            end
            write_burst(ra, rd, rm);
         end else begin
            read_model(ra, 0);
         end
      end

      // Reset during write beat 2: beats 2 and 3 must not land
      cmd = 1'b1; cmd_en = 1'b1; addr = 21'h60; data_mask = 8'h00;
      wr_data = 64'h0BAD_0000_0000_0000;
      tick(); model[12] = 64'h0BAD_0000_0000_0000;
      cmd_en = 1'b0; wr_data = 64'h0BAD_0000_0000_0001;
      tick(); model[13] = 64'h0BAD_0000_0000_0001;
      wr_data = 64'h0BAD_0000_0000_0002; rst_n = 1'b0;
      tick();
      chk1("wabort_busy", busy, 1'b0);
      chk1("wabort_init", init_calib, 1'b0);
      do_reset(0);
      read_model(21'h60, 0);

      // Reset during the second valid read beat
      cmd = 1'b0; cmd_en = 1'b1; addr = 21'h40;
      for (int k = 1; k <= L + 1; k++) begin
         tick();
         cmd_en = 1'b0;
         chk1("rabort_valid", rd_data_valid, k >= L);
      end
      chk64("rabort_beat1", rd_data, model[widx(21'h40, 1)]);
      rst_n = 1'b0;
      tick();
      chk1("rabort_valid_off", rd_data_valid, 1'b0);
      chk1("rabort_busy_off", busy, 1'b0);
      do_reset(0);
      read_model(21'h40, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_burst_ram
`default_nettype wire
